// File: rtl/regfile_wb_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_queue_if
// Purpose  : Producer-side push handshake of the register-file write-back
//            queue. The producer drives an entry (valid, destination, data);
//            the queue answers with ready.
// Ports    : push_valid  producer presents an entry
//            push_ready  queue accepts an entry this cycle
//            push_dest   target register of the entry
//            push_data   value to write
// Modports : master = producer, slave = queue
// Revision : 1.0  initial release
// ============================================================================
interface regfile_wb_queue_if #(
  parameter int WIDTH        = 16,
  parameter int ADDRESSWIDTH = 5
);
  logic                    push_valid;
  logic                    push_ready;
  logic [ADDRESSWIDTH-1:0] push_dest;
  logic [WIDTH-1:0]        push_data;

  modport master (output push_valid, output push_dest, output push_data,
                  input  push_ready);
  modport slave  (input  push_valid, input  push_dest, input  push_data,
                  output push_ready);
endinterface
`default_nettype wire

// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_queue
// Purpose  : In-order write-back queue in front of the register file's single
//            write port. Buffers (dest, data) pairs and drains one per cycle
//            into a registered output stage. Also reports whether a read
//            address still has a write pending.
// Ports    : clock, reset          clock; synchronous active-high reset
//            push (slave)          push_valid/push_ready/push_dest/push_data
//            drain_hold            suppress the pop on this edge
//            write_enable/dest/data_in  registered register-file write port
//            query_source          read address to check
//            query_hit             combinational pending-write flag
//            query_data            youngest pending data (forwarding build)
//            count                 queued entries, output stage excluded
// Config   : define WBQ_FORWARD_EN to add the query_data port and its
//            youngest-first select logic.
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_queue #(
  parameter int WIDTH        = 16,
  parameter int ADDRESSWIDTH = 5,
  parameter int QDEPTH       = 4,
  parameter int CW           = 3
) (
  input  wire logic                    clock,
  input  wire logic                    reset,
  regfile_wb_queue_if.slave            push,
  input  wire logic                    drain_hold,
  output logic                         write_enable,
  output logic [ADDRESSWIDTH-1:0]      dest,
  output logic [WIDTH-1:0]             data_in,
  input  wire logic [ADDRESSWIDTH-1:0] query_source,
  output logic                         query_hit,
  output logic [CW-1:0]                count
`ifdef WBQ_FORWARD_EN
  ,
  output logic [WIDTH-1:0]             query_data
`endif
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  typedef logic [PW-1:0] ptr_t;

  logic [ADDRESSWIDTH-1:0] mem_dest [QDEPTH];
  logic [WIDTH-1:0]        mem_data [QDEPTH];
  ptr_t                    head;
  ptr_t                    tail;
  logic [CW-1:0]           count_next;
  logic                    push_fire;
  logic                    pop;
  logic                    hit_raw;

  // Explicit wrap so non-power-of-two depths work.
  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(QDEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // No pop-through credit: a full queue refuses even when it pops this edge.
  assign push.push_ready = !reset && (count < CW'(QDEPTH));
  assign push_fire       = push.push_valid && push.push_ready;
  assign pop             = (count != '0) && !drain_hold;

  always_comb begin
    count_next = count;
    case ({push_fire, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      write_enable <= 1'b0;
      dest         <= '0;
      data_in      <= '0;
    end else begin
      if (push_fire) begin
        mem_dest[tail] <= push.push_dest;
        mem_data[tail] <= push.push_data;
        tail           <= next_ptr(tail);
      end
      if (pop) begin
        dest    <= mem_dest[head];
        data_in <= mem_data[head];
        head    <= next_ptr(head);
      end
      // dest/data_in deliberately hold when nothing pops.
      write_enable <= pop;
      count        <= count_next;
    end
  end

  // Pending-write search. The output stage is the oldest pending write, then
  // queue entries from head (oldest) to tail (youngest); later matches
  // override earlier ones so the forwarded value is the youngest.
`ifdef WBQ_FORWARD_EN
  logic [WIDTH-1:0] fwd_raw;
`endif

  always_comb begin : search
    ptr_t idx;
    idx     = '0;
    hit_raw = write_enable && (dest == query_source);
`ifdef WBQ_FORWARD_EN
    fwd_raw = data_in;
`endif
    for (int k = 0; k < QDEPTH; k++) begin
      idx = ptr_t'((int'(head) + k) % QDEPTH);
      if ((k < int'(count)) && (mem_dest[idx] == query_source)) begin
        hit_raw = 1'b1;
`ifdef WBQ_FORWARD_EN
        fwd_raw = mem_data[idx];
`endif
      end
    end
  end

  assign query_hit = hit_raw && !reset;

`ifdef WBQ_FORWARD_EN
  assign query_data = query_hit ? fwd_raw : '0;
`endif

endmodule
`default_nettype wire

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back queue that sits directly upstream of the register file's single write port. Result producers push (destination, data) pairs through a valid/ready handshake. The block buffers them in order and drains one entry per cycle into the register file's `write_enable`/`dest`/`data_in` inputs. It also reports whether a register-file read address has a write still pending, so the read side can stall or forward.

## Interface
Parameters:
- `WIDTH`, 16, data width; matches register-file data width.
- `ADDRESSWIDTH`, 5, register address width.
- `QDEPTH`, 4, queue entries; must be ≥ 2.
- `CW`, 3, width of `count`; requires 2^CW > QDEPTH.

Ports:
- `clock`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `push_valid`  in  1  producer presents an entry.
- `push_ready`  out  1  queue can accept an entry this cycle.
- `push_dest`  in  ADDRESSWIDTH  target register of the pushed entry.
- `push_data`  in  WIDTH  value to write.
- `drain_hold`  in  1  when 1, no entry is popped this cycle.
- `write_enable`  out  1  registered; drives register-file `write_enable`.
- `dest`  out  ADDRESSWIDTH  registered; drives register-file `dest`.
- `data_in`  out  WIDTH  registered; drives register-file `data_in`.
- `query_source`  in  ADDRESSWIDTH  read address to check; normally the register-file `source`.
- `query_hit`  out  1  combinational; a write to `query_source` is pending.
- `query_data`  out  WIDTH  combinational; present only with `WBQ_FORWARD_EN`.
- `count`  out  CW  registered; number of entries in the queue, excluding the output stage.

## Operation
- Circular buffer with `QDEPTH` entries, plus head and tail pointers. Both pointers wrap modulo `QDEPTH`.
- Push:
  - Accepted on an edge where `push_valid && push_ready`.
  - The entry is written at the tail and the tail advances.
  - `push_ready = !reset && (count < QDEPTH)`. There is no pop-through credit, so a full queue refuses a push even if it pops in the same cycle.
- Pop:
  - On an edge where `count != 0` and `!drain_hold`, the head entry loads into `dest`/`data_in`, `write_enable` is set to 1, and the head advances.
  - Otherwise `write_enable` is set to 0, and `dest`/`data_in` hold their previous values.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Entries with the same `dest` are never coalesced. They drain in push order, so the register file ends up with the youngest value.
- `query_hit` is 1 if any valid queue entry, or the output stage while `write_enable = 1`, has an address equal to `query_source`.
  - Entries that were pushed and popped on the current edge are not double-counted.
  - An entry becomes visible to the query in the cycle after it is accepted.
- Reset, when `reset = 1` at an edge:
  - Pointers, `count`, `write_enable`, `dest` and `data_in` all go to 0.
  - All queued writes are discarded, including mid-drain.
  - `push_ready = 0` and `query_hit = 0` while reset is asserted.

## Timing
- Reset values: `write_enable = 0`, `dest = 0`, `data_in = 0`, `count = 0`, `push_ready = 0` during reset and 1 after it, `query_hit = 0`.
- Latency, with an empty queue and no hold:
  - Push accepted at edge N.
  - Popped at edge N+1.
  - `write_enable = 1` during cycle N+1 to N+2.
  - The register file commits at edge N+2.
- Throughput: one write per cycle sustained. `push_ready` stays 1 while push and pop rates are equal.
- Full boundary: at `count = QDEPTH`, `push_ready = 0`, regardless of pop.
- Empty boundary: at `count = 0`, `write_enable` goes to 0 on the next edge.
- `drain_hold` takes effect on the same edge it is sampled; the write that is already in the output stage still completes.
- `query_hit` and `query_data` are purely combinational from state and `query_source`, with no cycle of delay.

## Configuration
- Macro: `WBQ_FORWARD_EN`.
- Defined:
  - `query_data` port exists.
  - It returns the data of the youngest pending write to `query_source`.
  - Priority is youngest queue entry first, then the output stage.
  - It is 0 when `query_hit = 0`.
- Undefined: the `query_data` port and the priority-select logic are removed. `query_hit` is unchanged.

## Test plan
- Reset, then push (`dest` 3, data 0x1234) at edge N → `write_enable = 1`, `dest = 3`, `data_in = 0x1234` during cycle N+1 to N+2, then `write_enable = 0`; `count` goes 0 → 1 → 0.
- Hold `drain_hold = 1` and push 5 entries with QDEPTH 4 → 4 accepted, `push_ready = 0` at `count = 4`, 5th producer stalls. Release hold → 4 writes on consecutive cycles in push order, then the 5th.
- Push (`dest` 7, 0xAAAA) then (`dest` 7, 0xBBBB) under hold, with `query_source = 7` → `query_hit = 1`. With the macro, `query_data = 0xBBBB`. After the drain, the register file holds 0xBBBB and `query_hit = 0`.
- Continuous push every cycle with no hold for 20 cycles → `write_enable` is stuck at 1 after the first output, `push_ready` never drops, and pointers wrap correctly (data sequence matches).
- Fill 3 entries, assert `reset` for 1 cycle mid-drain → next cycle `write_enable = 0`, `count = 0`, `query_hit = 0`; no discarded entries are ever written.
